// File: rtl/alu_nibble_serial_seq.sv
// Nibble-serial sequencer for a 4-bit flag-ALU slice: runs W-bit operations one
// nibble per clock, LSB first, chaining slice carry and assembling result/flags.
module alu_nibble_serial_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [2:0]             op_s,
  input  logic                   carry_in,
  input  logic [4*NIBBLES-1:0]   a_in,
  input  logic [4*NIBBLES-1:0]   b_in,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   carry_out,
  output logic                   zero,
  output logic                   negative,
  output logic                   overflow,
  output logic [3:0]             alu_A,
  output logic [3:0]             alu_B,
  output logic [2:0]             alu_S,
  output logic                   alu_Cn,
  input  logic [3:0]             alu_F,
  input  logic                   alu_Co,
  input  logic                   alu_Overflow
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t             state;
  logic [W-1:0]       a_reg;
  logic [W-1:0]       b_reg;
  logic [2:0]         op_reg;
  logic               carry_reg;
  logic [IDX_W-1:0]   idx;
  logic               last;
  logic               arith;

  assign last  = (idx == IDX_W'(NIBBLES - 1));
  assign arith = (op_reg == 3'b001) || (op_reg == 3'b010) || (op_reg == 3'b011);

  // Slice inputs are a pure decode of the registered operands and nibble index.
  always_comb begin
    alu_A  = 4'h0;
    alu_B  = 4'h0;
    alu_S  = 3'b000;
    alu_Cn = 1'b0;
    if (state == RUN) begin
      alu_S  = op_reg;
      alu_Cn = carry_reg;
      for (int n = 0; n < NIBBLES; n++) begin
        if (idx == IDX_W'(n)) begin
          alu_A = a_reg[4*n +: 4];
          alu_B = b_reg[4*n +: 4];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= 3'b000;
      carry_reg <= 1'b0;
      idx       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      zero      <= 1'b0;
      negative  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg     <= a_in;
            b_reg     <= b_in;
            op_reg    <= op_s;
            carry_reg <= carry_in;
            idx       <= '0;
            busy      <= 1'b1;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
            negative  <= 1'b0;
            overflow  <= 1'b0;
            state     <= RUN;
          end
        end
        RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (idx == IDX_W'(n)) begin
              result[4*n +: 4] <= alu_F;
            end
          end
          carry_reg <= alu_Co;
          if (last) begin
            // Nibbles not yet written are still zero, so the whole register
            // stands in for "lower nibbles stored so far".
            carry_out <= arith & alu_Co;
            overflow  <= arith & alu_Overflow;
            negative  <= alu_F[3];
            zero      <= (result == '0) && (alu_F == 4'h0);
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_nibble_serial_seq.sv
// Scoreboard bench for alu_nibble_serial_seq: a behavioural 4-bit slice closes
// the loop, and a wide-arithmetic model predicts each completed operation.
module tb_alu_nibble_serial_seq;

  localparam int NIB = 4;
  localparam int W   = 4 * NIB;

  typedef struct packed {
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         negative;
    logic         overflow;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [2:0]   op_s;
  logic         carry_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         zero;
  logic         negative;
  logic         overflow;
  logic [3:0]   alu_A;
  logic [3:0]   alu_B;
  logic [2:0]   alu_S;
  logic         alu_Cn;
  logic [3:0]   alu_F;
  logic         alu_Co;
  logic         alu_Overflow;

  int   checks;
  int   failures;
  exp_t sb[$];
  exp_t mon_exp;

  logic [4:0] slice_sum;
  logic [3:0] slice_x;
  logic [3:0] slice_y;

  alu_nibble_serial_seq #(.NIBBLES(NIB)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .op_s         (op_s),
    .carry_in     (carry_in),
    .a_in         (a_in),
    .b_in         (b_in),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .carry_out    (carry_out),
    .zero         (zero),
    .negative     (negative),
    .overflow     (overflow),
    .alu_A        (alu_A),
    .alu_B        (alu_B),
    .alu_S        (alu_S),
    .alu_Cn       (alu_Cn),
    .alu_F        (alu_F),
    .alu_Co       (alu_Co),
    .alu_Overflow (alu_Overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural slice; for logic ops Co/Overflow are don't-cares, driven high
  // so that any failure to mask them shows up in the flags.
  always_comb begin
    slice_x      = alu_A;
    slice_y      = alu_B;
    slice_sum    = 5'h0;
    alu_F        = 4'h0;
    alu_Co       = 1'b1;
    alu_Overflow = 1'b1;
    case (alu_S)
      3'b000: alu_F = 4'h0;
      3'b100: alu_F = alu_A ^ alu_B;
      3'b101: alu_F = alu_A | alu_B;
      3'b110: alu_F = alu_A & alu_B;
      3'b111: alu_F = 4'hF;
      default: begin
        if (alu_S == 3'b001) begin
          slice_x = alu_B;
          slice_y = ~alu_A;
        end else if (alu_S == 3'b010) begin
          slice_y = ~alu_B;
        end
        slice_sum    = {1'b0, slice_x} + {1'b0, slice_y} + {4'h0, alu_Cn};
        alu_F        = slice_sum[3:0];
        alu_Co       = slice_sum[4];
        alu_Overflow = (slice_x[3] == slice_y[3]) && (slice_sum[3] != slice_x[3]);
      end
    endcase
  end

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op, input logic cin);
    exp_t       e;
    logic [W:0] sum;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic       ar;
    e  = '0;
    x  = a;
    y  = b;
    ar = 1'b0;
    case (op)
      3'b000: e.result = '0;
      3'b001: begin x = b; y = ~a; ar = 1'b1; end
      3'b010: begin y = ~b; ar = 1'b1; end
      3'b011: ar = 1'b1;
      3'b100: e.result = a ^ b;
      3'b101: e.result = a | b;
      3'b110: e.result = a & b;
      default: e.result = '1;
    endcase
    if (ar) begin
      sum        = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, cin};
      e.result   = sum[W-1:0];
      e.carry    = sum[W];
      e.overflow = (x[W-1] == y[W-1]) && (e.result[W-1] != x[W-1]);
    end
    e.zero     = (e.result == '0);
    e.negative = e.result[W-1];
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_done: got done=1 expected no pending operation");
      end else begin
        mon_exp = sb.pop_front();
        checkOutput("result",    32'(result),    32'(mon_exp.result));
        checkOutput("carry_out", 32'(carry_out), 32'(mon_exp.carry));
        checkOutput("zero",      32'(zero),      32'(mon_exp.zero));
        checkOutput("negative",  32'(negative),  32'(mon_exp.negative));
        checkOutput("overflow",  32'(overflow),  32'(mon_exp.overflow));
        checkOutput("busy_in_done", 32'(busy), 32'd1);
      end
    end
  end

  task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2:0] op, input logic cin);
    exp_t e;
    int   cyc;
    logic seq_ok;
    e = model(a, b, op, cin);
    @(negedge clk);
    a_in     = a;
    b_in     = b;
    op_s     = op;
    carry_in = cin;
    start    = 1'b1;
    sb.push_back(e);
    @(negedge clk);
    start    = 1'b0;
    a_in     = W'($urandom);
    b_in     = W'($urandom);
    op_s     = 3'($urandom_range(0, 7));
    carry_in = 1'($urandom_range(0, 1));
    cyc      = 1;
    seq_ok   = 1'b1;
    while (done !== 1'b1 && cyc <= 4 * NIB + 4) begin
      if (cyc <= NIB) begin
        if (alu_A !== a[4*(cyc-1) +: 4] || alu_B !== b[4*(cyc-1) +: 4] || alu_S !== op)
          seq_ok = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    checkOutput("done_latency", 32'(cyc), 32'(NIB + 1));
    checkOutput("alu_sequence", 32'(seq_ok), 32'd1);
    @(negedge clk);
    checkOutput("busy_after_done", 32'(busy), 32'd0);
    checkOutput("result_hold", 32'(result), 32'(e.result));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    exp_t         ex;
    int           cyc;
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    start    = 1'b0;
    op_s     = 3'b000;
    carry_in = 1'b0;
    a_in     = '0;
    b_in     = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy",     32'(busy),      32'd0);
    checkOutput("rst_done",     32'(done),      32'd0);
    checkOutput("rst_result",   32'(result),    32'd0);
    checkOutput("rst_flags",    32'({carry_out, zero, negative, overflow}), 32'd0);
    checkOutput("rst_alu_A",    32'(alu_A),     32'd0);
    checkOutput("rst_alu_B",    32'(alu_B),     32'd0);
    checkOutput("rst_alu_S",    32'(alu_S),     32'd0);
    checkOutput("rst_alu_Cn",   32'(alu_Cn),    32'd0);
    rst = 1'b0;

    applyStimulus(16'h1234, 16'h0FFF, 3'b011, 1'b0);
    applyStimulus(16'hFFFF, 16'h0001, 3'b011, 1'b0);
    applyStimulus(16'h8000, 16'h0001, 3'b010, 1'b1);
    applyStimulus(16'h7FFF, 16'h0001, 3'b011, 1'b0);
    applyStimulus(16'hF0F0, 16'h0FF0, 3'b110, 1'b0);
    applyStimulus(16'h0003, 16'h0005, 3'b001, 1'b1);
    applyStimulus(16'h5A5A, 16'h5A5A, 3'b100, 1'b0);
    applyStimulus(16'h1234, 16'h4321, 3'b101, 1'b1);
    applyStimulus(16'hABCD, 16'h1111, 3'b000, 1'b1);
    applyStimulus(16'h0000, 16'h0000, 3'b111, 1'b0);

    // Abort: reset lands on the second RUN edge, nothing may complete.
    @(negedge clk);
    a_in = 16'h1111; b_in = 16'h2222; op_s = 3'b011; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_busy",   32'(busy),   32'd0);
    checkOutput("abort_result", 32'(result), 32'd0);
    checkOutput("abort_done",   32'(done),   32'd0);
    rst = 1'b0;
    repeat (NIB + 2) @(negedge clk);

    // Starts issued during RUN and during DONE must be ignored.
    ex = model(16'h4444, 16'h0123, 3'b010, 1'b1);
    a_in = 16'h4444; b_in = 16'h0123; op_s = 3'b010; carry_in = 1'b1; start = 1'b1;
    sb.push_back(ex);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a_in = 16'hFFFF; b_in = 16'hFFFF; op_s = 3'b011; carry_in = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 4 * NIB + 4) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("busy_test_done_seen", 32'(done), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("start_in_done_ignored", 32'(busy), 32'd0);
    checkOutput("busy_test_hold", 32'(result), 32'(ex.result));
    repeat (NIB + 2) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 5 == 0) rb = ra;
      applyStimulus(ra, rb, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
